// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer driving one external full-adder cell
//
// Purpose:
//   Adds two WIDTH-bit operands plus a carry-in by feeding one bit pair per
//   cycle, LSB first, through an external combinational full-adder cell.
//   The sequencer owns the operand shift registers, the carry flop, the bit
//   counter, the partial-sum shifter and the registered result. Handshaking
//   uses a start request, an abort cancel, a busy level and a one-cycle done
//   pulse.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start    request, sampled only in IDLE
//   abort    synchronous cancel, effective only in RUN
//   a, b     WIDTH-bit operands, captured on the accept edge
//   cin      carry-in, captured on the accept edge
//   busy     high while in RUN
//   done     one-cycle completion pulse (DONE state)
//   sum      registered result, held until the next completion
//   cout     registered carry-out, held until the next completion
//   fa_a     bit to full-adder a pin
//   fa_b     bit to full-adder b pin
//   fa_cin   carry to full-adder cin pin
//   fa_sum   full-adder sum pin
//   fa_cout  full-adder cout pin

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    // A 1-bit counter is kept even for WIDTH=1 so the compare below is legal.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] DONE_ST = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    // Partial sum after folding in the bit the adder is producing right now.
    logic [WIDTH-1:0] next_s;

    generate
        if (WIDTH == 1) begin : g_w1
            assign next_s = fa_sum;
        end else begin : g_wn
            assign next_s = {fa_sum, s_sh[WIDTH-1:1]};
        end
    endgenerate

    // The LSB of the shifter is always shifted out before it could matter.
    logic unused_s_lsb;
    assign unused_s_lsb = s_sh[0];

    logic in_run;
    assign in_run = (state == RUN);

    // Zero-delay path to the adder cell; gated so the cell sees 0 when idle.
    assign fa_a   = in_run & a_sh[0];
    assign fa_b   = in_run & b_sh[0];
    assign fa_cin = in_run & carry;

    assign busy = in_run;
    assign done = (state == DONE_ST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Cancel wins even on the last bit, so the result
                    // registers keep the previous completion's value.
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        a_sh  <= a_sh >> 1;
                        b_sh  <= b_sh >> 1;
                        s_sh  <= next_s;
                        carry <= fa_cout;
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST_BIT) begin
                            sum   <= next_s;
                            cout  <= fa_cout;
                            state <= DONE_ST;
                        end
                    end
                end
                DONE_ST: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed and random checks of serial_add_ctrl at WIDTH=8 and WIDTH=1

module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // WIDTH=8 instance
    logic       start8 = 1'b0;
    logic       abort8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       fa_a8, fa_b8, fa_cin8, fa_sum8, fa_cout8;

    // WIDTH=1 instance
    logic       start1 = 1'b0;
    logic       abort1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;
    logic       fa_a1, fa_b1, fa_cin1, fa_sum1, fa_cout1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    // Gate-level style full-adder cells, one per instance.
    assign fa_sum8  = fa_a8 ^ fa_b8 ^ fa_cin8;
    assign fa_cout8 = (fa_a8 & fa_b8) | (fa_a8 & fa_cin8) | (fa_b8 & fa_cin8);
    assign fa_sum1  = fa_a1 ^ fa_b1 ^ fa_cin1;
    assign fa_cout1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort8),
        .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
        .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8),
        .fa_sum(fa_sum8), .fa_cout(fa_cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1),
        .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1),
        .fa_sum(fa_sum1), .fa_cout(fa_cout1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // Accept one WIDTH=8 request, then count busy cycles up to the done pulse.
    task automatic add8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                        output int busy_n, output int got_done);
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = ci; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        busy_n = 0;
        got_done = 0;
        for (int i = 0; i < 30; i++) begin
            if (done8) begin
                got_done = 1;
                break;
            end
            if (busy8) busy_n++;
            @(negedge clk);
        end
        if (got_done == 0) check("add8_timeout", 32'd0, 32'd1);
    endtask

    int bn, dn, dcount;
    logic [8:0] exp9;

    initial begin
        // Reset state
        #2;
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_sum",  {24'd0, sum8},  32'd0);
        check("rst_cout", {31'd0, cout8}, 32'd0);
        check("rst_fa_a", {31'd0, fa_a8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 0x5A + 0x3C: 8 busy cycles, done in the 9th
        add8(8'h5A, 8'h3C, 1'b0, bn, dn);
        check("basic_busy_cycles", bn, 32'd8);
        check("basic_busy_at_done", {31'd0, busy8}, 32'd0);
        check("basic_sum", {24'd0, sum8}, 32'h96);
        check("basic_cout", {31'd0, cout8}, 32'd0);
        @(negedge clk);
        check("basic_done_one_cycle", {31'd0, done8}, 32'd0);
        check("idle_fa_cin", {31'd0, fa_cin8}, 32'd0);

        add8(8'hFF, 8'h01, 1'b0, bn, dn);
        check("ff01_res", {23'd0, cout8, sum8}, 32'h100);
        add8(8'hFF, 8'h00, 1'b1, bn, dn);
        check("ff00c_res", {23'd0, cout8, sum8}, 32'h100);
        add8(8'h00, 8'h00, 1'b0, bn, dn);
        check("zero_res", {23'd0, cout8, sum8}, 32'h000);

        // Start while running is ignored
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            if (done8) dcount++;
            @(negedge clk);
        end
        check("ignore_start_dones", dcount, 32'd1);
        check("ignore_start_res", {23'd0, cout8, sum8}, 32'h046);

        // Abort at RUN cycle 5 keeps the previous result
        add8(8'h01, 8'h01, 1'b0, bn, dn);
        check("pre_abort_sum", {24'd0, sum8}, 32'h02);
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        abort8 = 1'b1;
        @(negedge clk);
        abort8 = 1'b0;
        check("abort_busy", {31'd0, busy8}, 32'd0);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) dcount++;
            @(negedge clk);
        end
        check("abort_no_done", dcount, 32'd0);
        check("abort_sum", {24'd0, sum8}, 32'h02);
        check("abort_cout", {31'd0, cout8}, 32'd0);

        // Asynchronous reset mid-run
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h44; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy8}, 32'd0);
        check("arst_done", {31'd0, done8}, 32'd0);
        check("arst_sum",  {24'd0, sum8},  32'd0);
        check("arst_cout", {31'd0, cout8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        add8(8'h0F, 8'h01, 1'b0, bn, dn);
        check("post_rst_sum", {23'd0, cout8, sum8}, 32'h010);

        // WIDTH=1: 1+1+1 = 0b11
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("w1_busy", {31'd0, busy1}, 32'd1);
        @(negedge clk);
        check("w1_done", {31'd0, done1}, 32'd1);
        check("w1_busy_off", {31'd0, busy1}, 32'd0);
        check("w1_res", {30'd0, cout1, sum1}, 32'd3);

        // Random WIDTH=8 vectors
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra, rb;
            logic       rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            add8(ra, rb, rc, bn, dn);
            check("rand_res", {23'd0, cout8, sum8}, {23'd0, exp9});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
